// File: rtl/mlp_fc_argmax.sv
// ---------------------------------------------------------------------------
// mlp_fc_argmax
//
// Purpose:
//   Parametrised fully-connected output layer followed by an argmax. For each
//   neuron n it streams one sample's features and that neuron's weights (and
//   bias) out of two external synchronous-read memories. It accumulates the
//   signed dot product plus bias and keeps the best-scoring class seen so far.
//   At the end it reports the winning class index and its score.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   start     in   one-cycle run request, honoured only while idle
//   test_num  in   sample index, captured when start is accepted
//   x_addr    out  feature memory address {sample, j}
//   x_data    in   feature data, valid the cycle after x_addr
//   w_addr    out  weight memory address {neuron, j}; j == N_IN is the bias
//   w_data    in   weight/bias data, valid the cycle after w_addr
//   out       out  winning class index (updated only when a run finishes)
//   score     out  winning class score (updated only when a run finishes)
//   busy      out  high from accepted start until done rises
//   done      out  level, high after completion until the next accepted start
//
// Optional build macro:
//   MLP_FC_RELU_EN  when defined, each neuron's score is clamped to max(acc,0)
//                   before comparison and reporting. Latency is unchanged.
// ---------------------------------------------------------------------------
module mlp_fc_argmax #(
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 24,
    parameter int N_IN      = 16,
    parameter int N_OUT     = 10,
    parameter int IN_IDX_W  = 5,
    parameter int OUT_IDX_W = 4,
    parameter int SAMPLE_W  = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [SAMPLE_W-1:0]            test_num,
    output logic [SAMPLE_W+IN_IDX_W-1:0]   x_addr,
    input  logic [DATA_W-1:0]              x_data,
    output logic [OUT_IDX_W+IN_IDX_W-1:0]  w_addr,
    input  logic [DATA_W-1:0]              w_data,
    output logic [OUT_IDX_W-1:0]           out,
    output logic [ACC_W-1:0]               score,
    output logic                           busy,
    output logic                           done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_CMP,
        S_FIN
    } state_t;

    localparam logic [IN_IDX_W-1:0]  LAST_J = IN_IDX_W'(N_IN);
    localparam logic [OUT_IDX_W-1:0] LAST_N = OUT_IDX_W'(N_OUT - 1);

    state_t                  state;
    logic [SAMPLE_W-1:0]     sample;
    logic [OUT_IDX_W-1:0]    n;
    logic [IN_IDX_W-1:0]     j;
    logic                    pend;
    logic                    pend_bias;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] max_val;
    logic [OUT_IDX_W-1:0]    idx;

    logic signed [2*DATA_W-1:0] x_ext;
    logic signed [2*DATA_W-1:0] w_ext;
    logic signed [2*DATA_W-1:0] product;
    logic signed [ACC_W-1:0]    term;
    logic signed [ACC_W-1:0]    cand;

    // Addresses come straight from the index registers, so the memories see
    // {sample,j} / {n,j} in the same cycle the FSM is at that index.
    assign x_addr = {sample, j};
    assign w_addr = {n, j};

    // Memory data returns one cycle after its address; pend/pend_bias are the
    // one-cycle-delayed "data valid" and "this beat is the bias" flags.
    // Operands are sign-extended to the product width so the multiply yields
    // the full signed product.
    always_comb begin
        x_ext   = {{DATA_W{x_data[DATA_W-1]}}, x_data};
        w_ext   = {{DATA_W{w_data[DATA_W-1]}}, w_data};
        product = x_ext * w_ext;
        term    = '0;
        if (pend_bias) begin
            term = {{(ACC_W-DATA_W){w_data[DATA_W-1]}}, w_data};
        end else begin
            term = {{(ACC_W-2*DATA_W){product[2*DATA_W-1]}}, product};
        end
    end

    // Value that a finished neuron competes with: the raw accumulator, or the
    // accumulator clamped at zero in the ReLU build.
    always_comb begin
        cand = acc;
`ifdef MLP_FC_RELU_EN
        if (acc[ACC_W-1]) begin
            cand = '0;
        end
`else
`endif
    end

    // Main controller: issues one address per cycle for j = 0..N_IN, lets the
    // final beat drain, compares the neuron against the running maximum, and
    // after the last neuron publishes the result. The accumulate step runs
    // whenever a data beat is pending, independent of the current state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            sample    <= '0;
            n         <= '0;
            j         <= '0;
            pend      <= 1'b0;
            pend_bias <= 1'b0;
            acc       <= '0;
            max_val   <= '0;
            idx       <= '0;
            out       <= '0;
            score     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (pend) begin
                acc <= acc + term;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        sample    <= test_num;
                        n         <= '0;
                        j         <= '0;
                        max_val   <= '0;
                        idx       <= '0;
                        acc       <= '0;
                        pend      <= 1'b0;
                        pend_bias <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        state     <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    pend      <= 1'b1;
                    pend_bias <= (j == LAST_J);
                    if (j == LAST_J) begin
                        j     <= '0;
                        state <= S_DRAIN;
                    end else begin
                        j <= j + 1'b1;
                    end
                end

                S_DRAIN: begin
                    pend      <= 1'b0;
                    pend_bias <= 1'b0;
                    state     <= S_CMP;
                end

                S_CMP: begin
                    // Strict compare keeps the lowest index on ties.
                    if ((n == '0) || (cand > max_val)) begin
                        max_val <= cand;
                        idx     <= n;
                    end
                    acc <= '0;
                    if (n == LAST_N) begin
                        state <= S_FIN;
                    end else begin
                        n     <= n + 1'b1;
                        state <= S_ISSUE;
                    end
                end

                S_FIN: begin
                    out   <= idx;
                    score <= max_val;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_fc_argmax.sv
// ---------------------------------------------------------------------------
// tb_mlp_fc_argmax
//
// Purpose:
//   Self-checking bench for mlp_fc_argmax with N_IN=4, N_OUT=3, DATA_W=8,
//   ACC_W=20. Feature and weight memories are modelled as synchronous-read
//   arrays. Directed vectors come from a table with hand-computed results.
//   Randomised samples are checked against a plain-arithmetic reference that
//   computes every neuron's dot product and picks the lowest-index maximum.
//
// Ports: none (top-level bench).
//
// Optional build macro:
//   MLP_FC_RELU_EN  selects the clamped-score expectations.
// ---------------------------------------------------------------------------
module tb_mlp_fc_argmax;

    localparam int DW = 8;
    localparam int AW = 20;
    localparam int NI = 4;
    localparam int NO = 3;
    localparam int IW = 3;
    localparam int OW = 2;
    localparam int SW = 4;
    localparam int LAT = NO * (NI + 3) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [SW-1:0]     test_num = '0;
    logic [SW+IW-1:0]  x_addr;
    logic [DW-1:0]     x_data;
    logic [OW+IW-1:0]  w_addr;
    logic [DW-1:0]     w_data;
    logic [OW-1:0]     out;
    logic [AW-1:0]     score;
    logic              busy;
    logic              done;

    int errors = 0;
    int checks = 0;
    int last_out = 0;
    longint last_score = 0;

    logic [DW-1:0] xmem [0:(1<<(SW+IW))-1];
    logic [DW-1:0] wmem [0:(1<<(OW+IW))-1];

    typedef logic [0:4][7:0] row_t;

    typedef struct packed {
        int   tnum;
        row_t x;
        row_t w0;
        row_t w1;
        row_t w2;
        int   exp_out;
        int   exp_score;
    } vec_t;

    vec_t vecs [5];

    mlp_fc_argmax #(
        .DATA_W(DW), .ACC_W(AW), .N_IN(NI), .N_OUT(NO),
        .IN_IDX_W(IW), .OUT_IDX_W(OW), .SAMPLE_W(SW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .test_num(test_num),
        .x_addr(x_addr), .x_data(x_data), .w_addr(w_addr), .w_data(w_data),
        .out(out), .score(score), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories: data appears the cycle after the address.
    always @(posedge clk) begin
        x_data <= xmem[x_addr];
        w_data <= wmem[w_addr];
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    function automatic row_t row5(input int a, input int b, input int c, input int d, input int e);
        row_t r;
        r[0] = 8'(a);
        r[1] = 8'(b);
        r[2] = 8'(c);
        r[3] = 8'(d);
        r[4] = 8'(e);
        return r;
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic load_vec(input vec_t v);
        for (int j = 0; j < NI; j++) xmem[(v.tnum << IW) + j] = v.x[j];
        for (int j = 0; j <= NI; j++) begin
            wmem[(0 << IW) + j] = v.w0[j];
            wmem[(1 << IW) + j] = v.w1[j];
            wmem[(2 << IW) + j] = v.w2[j];
        end
    endtask

    // Reference: each neuron's score is bias + sum of signed products; the
    // winner is the first neuron whose score is strictly the largest.
    task automatic model(input int tnum, output int eo, output longint es);
        longint s;
        int xv, wv;
        eo = 0;
        es = 0;
        for (int n = 0; n < NO; n++) begin
            wv = int'($signed(wmem[(n << IW) + NI]));
            s = wv;
            for (int j = 0; j < NI; j++) begin
                xv = int'($signed(xmem[(tnum << IW) + j]));
                wv = int'($signed(wmem[(n << IW) + j]));
                s += longint'(xv * wv);
            end
`ifdef MLP_FC_RELU_EN
            if (s < 0) s = 0;
`else
`endif
            if (n == 0 || s > es) begin
                es = s;
                eo = n;
            end
        end
    endtask

    // Launches one run and waits (bounded) for done; lat is the number of
    // edges from the start-sampling edge to the edge that raised done.
    task automatic applyStimulus(input int tnum, output int lat);
        @(posedge clk); #1;
        test_num = SW'(tnum);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                checkOutput("busy_during_run", longint'(busy), 1);
                checkOutput("done_cleared", longint'(done), 0);
                checkOutput("x_addr_sample", longint'(x_addr[IW +: SW]), tnum);
                checkOutput("hold_out", longint'(out), last_out);
                checkOutput("hold_score", longint'($signed(score)), last_score);
            end
            if (done) break;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL run_timeout: done=%0d, expected 1 within 200 cycles", done);
        end
    endtask

    task automatic run_and_check(input string tag, input int tnum, input int eo, input longint es);
        int lat;
        applyStimulus(tnum, lat);
        checkOutput({tag, "_out"}, longint'(out), eo);
        checkOutput({tag, "_score"}, longint'($signed(score)), es);
        checkOutput({tag, "_latency"}, lat, LAT);
        checkOutput({tag, "_busy_low"}, longint'(busy), 0);
        last_out = eo;
        last_score = es;
    endtask

    initial begin
        int eo;
        longint es;
        int cnt;

        for (int i = 0; i < (1<<(SW+IW)); i++) xmem[i] = '0;
        for (int i = 0; i < (1<<(OW+IW)); i++) wmem[i] = '0;

        // Directed table: hand-computed scores for each neuron.
        vecs[0].tnum = 2; vecs[0].x = row5(1, 2, 3, 4, 0);
        vecs[0].w0 = row5(1, 1, 1, 1, 0); vecs[0].w1 = row5(2, 0, 0, 0, 5);
        vecs[0].w2 = row5(0, 0, 0, 1, -1);
        vecs[0].exp_out = 0; vecs[0].exp_score = 10;

        vecs[1].tnum = 1; vecs[1].x = row5(-128, -128, -128, -128, 0);
        vecs[1].w0 = row5(0, 0, 0, 0, 0); vecs[1].w1 = row5(-128, -128, -128, -128, 127);
        vecs[1].w2 = row5(0, 0, 0, 0, 0);
        vecs[1].exp_out = 1; vecs[1].exp_score = 65663;

        vecs[2].tnum = 0; vecs[2].x = row5(1, 2, 3, 4, 0);
        vecs[2].w0 = row5(0, 0, 0, 0, 4); vecs[2].w1 = row5(0, 0, 0, 0, 4);
        vecs[2].w2 = row5(0, 0, 0, 0, 2);
        vecs[2].exp_out = 0; vecs[2].exp_score = 4;

        vecs[3].tnum = 0; vecs[3].x = row5(1, 2, 3, 4, 0);
        vecs[3].w0 = row5(0, 0, 0, 0, 2); vecs[3].w1 = row5(0, 0, 0, 0, 4);
        vecs[3].w2 = row5(0, 0, 0, 0, 4);
        vecs[3].exp_out = 1; vecs[3].exp_score = 4;

        vecs[4].tnum = 3; vecs[4].x = row5(7, -3, 9, 1, 0);
        vecs[4].w0 = row5(0, 0, 0, 0, -5); vecs[4].w1 = row5(0, 0, 0, 0, -3);
        vecs[4].w2 = row5(0, 0, 0, 0, -9);
`ifdef MLP_FC_RELU_EN
        vecs[4].exp_out = 0; vecs[4].exp_score = 0;
`else
        vecs[4].exp_out = 1; vecs[4].exp_score = -3;
`endif

        // Reset state
        #12;
        checkOutput("reset_out", longint'(out), 0);
        checkOutput("reset_score", longint'(score), 0);
        checkOutput("reset_done", longint'(done), 0);
        checkOutput("reset_busy", longint'(busy), 0);
        checkOutput("reset_x_addr", longint'(x_addr), 0);
        checkOutput("reset_w_addr", longint'(w_addr), 0);
        #3 rst = 1'b1;

        for (int k = 0; k < 5; k++) begin
            load_vec(vecs[k]);
            run_and_check($sformatf("vec%0d", k), vecs[k].tnum, vecs[k].exp_out,
                          longint'(vecs[k].exp_score));
        end

        // Mid-run asynchronous reset, then a clean run.
        load_vec(vecs[0]);
        @(posedge clk); #1;
        test_num = 4'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("midreset_out", longint'(out), 0);
        checkOutput("midreset_score", longint'(score), 0);
        checkOutput("midreset_done", longint'(done), 0);
        checkOutput("midreset_busy", longint'(busy), 0);
        @(posedge clk); #3 rst = 1'b1;
        last_out = 0;
        last_score = 0;
        run_and_check("after_reset", 2, 0, 10);

        // Handshake: pulses while busy are ignored; start held over the finish
        // cycle is accepted exactly one cycle later.
        @(posedge clk); #1;
        test_num = 4'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0;
        while (cnt < LAT + 1 + LAT) begin
            @(posedge clk); #1;
            cnt++;
            if (cnt == 3 || cnt == 10) start = 1'b1;
            if (cnt == 4 || cnt == 11) start = 1'b0;
            if (cnt == LAT - 2) start = 1'b1;
            if (cnt == LAT - 1) checkOutput("hs_done_not_early", longint'(done), 0);
            if (cnt == LAT) begin
                checkOutput("hs_done_first", longint'(done), 1);
                checkOutput("hs_busy_first", longint'(busy), 0);
                checkOutput("hs_out_first", longint'(out), 0);
            end
            if (cnt == LAT + 1) begin
                checkOutput("hs_restart_done", longint'(done), 0);
                checkOutput("hs_restart_busy", longint'(busy), 1);
                start = 1'b0;
            end
            if (cnt == 2 * LAT) checkOutput("hs_second_not_early", longint'(done), 0);
        end
        checkOutput("hs_done_second", longint'(done), 1);
        checkOutput("hs_score_second", longint'($signed(score)), 10);
        repeat (30) @(posedge clk);
        #1;
        checkOutput("hs_no_third_run", longint'(busy), 0);
        checkOutput("hs_done_holds", longint'(done), 1);
        last_out = 0;
        last_score = 10;

        // Randomised sweep over samples 0..3, then random sample/range rounds.
        for (int i = 0; i < (1<<(SW+IW)); i++) xmem[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < (1<<(OW+IW)); i++) wmem[i] = 8'($urandom_range(0, 255));
        for (int t = 0; t < 4; t++) begin
            model(t, eo, es);
            run_and_check($sformatf("sweep%0d", t), t, eo, es);
        end
        for (int r = 0; r < 6; r++) begin
            int t;
            for (int i = 0; i < (1<<(SW+IW)); i++) begin
                if (r < 3) xmem[i] = 8'($urandom_range(0, 255));
                else       xmem[i] = 8'(int'($urandom_range(0, 2)) - 1);
            end
            for (int i = 0; i < (1<<(OW+IW)); i++) begin
                if (r < 3) wmem[i] = 8'($urandom_range(0, 255));
                else       wmem[i] = 8'(int'($urandom_range(0, 2)) - 1);
            end
            t = int'($urandom_range(0, 15));
            model(t, eo, es);
            run_and_check($sformatf("rand%0d", r), t, eo, es);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
